// File: rtl/interleaver_pkg.sv
// -----------------------------------------------------------------------------
// interleaver_pkg
//   Shared definitions for the ROWS x COLS block interleaver.
//   - Default geometry (4x4) and the default pad value.
//   - depth_of / cnt_w_of derive the block size and the counter width from the
//     geometry, so every user sizes its counters the same way.
//   - perm(k) maps the k-th bit read out (column-major) to the storage address
//     it was written to (row-major).
// -----------------------------------------------------------------------------
package interleaver_pkg;

    localparam int   DEF_ROWS    = 4;
    localparam int   DEF_COLS    = 4;
    localparam logic DEF_PAD_BIT = 1'b0;

    // Number of bits in one interleave block.
    function automatic int depth_of(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Counter width for a block of the given depth (at least one bit).
    function automatic int cnt_w_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_DEPTH = depth_of(DEF_ROWS, DEF_COLS);
    localparam int DEF_CNT_W = cnt_w_of(DEF_DEPTH);

    // Read index k walks down a column first: row = k % rows, column = k / rows.
    // The bit at (row, col) was written at row-major address row*cols + col.
    function automatic int perm(input int k, input int rows, input int cols);
        return (k % rows) * cols + (k / rows);
    endfunction

endpackage

// File: rtl/ilv_bank.sv
// -----------------------------------------------------------------------------
// ilv_bank
//   One DEPTH-bit storage bank of the ping-pong interleaver.
//   Ports:
//     clk    in   system clock, posedge
//     rst    in   synchronous active-high reset, fills the bank with PAD_BIT
//     we     in   write enable for waddr
//     waddr  in   write address (row-major position)
//     wdata  in   bit to store
//     clr    in   synchronous clear of the whole bank to PAD_BIT
//     raddr  in   read address
//     rdata  out  combinational read of mem[raddr]
//   The bank is cleared once its block has been read out, so a later partial
//   (flushed) block finds PAD_BIT in every position it never wrote.
// -----------------------------------------------------------------------------
module ilv_bank
    import interleaver_pkg::*;
#(
    parameter int   DEPTH   = DEF_DEPTH,
    parameter int   ADDR_W  = DEF_CNT_W,
    parameter logic PAD_BIT = DEF_PAD_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);

    logic [DEPTH-1:0] mem;

    // NOTE: this storage is reset on purpose: unwritten positions of a flushed
    // block must read as PAD_BIT, so it is held in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mem <= {DEPTH{PAD_BIT}};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/block_interleaver.sv
// -----------------------------------------------------------------------------
// block_interleaver
//   Transmit-side ROWS x COLS bit block interleaver with two ping-pong banks.
//   Serial bits are written row-major into the write bank; each full bank is
//   read column-major while the other bank fills. 1 bit/clk in and out when
//   not back-pressured.
//   Ports:
//     clk        in   system clock, posedge
//     rst        in   synchronous reset, active-high; discards all blocks
//     in_valid   in   in_data valid
//     in_ready   out  a bit can be accepted this cycle
//     in_data    in   serial coded bit
//     in_flush   in   close the current partial block, pad with PAD_BIT
//     out_valid  out  out_data valid
//     out_ready  in   downstream takes out_data this cycle
//     out_data   out  interleaved bit
//     out_first  out  first bit of a block (receiver alignment)
//     out_last   out  last bit of a block
// -----------------------------------------------------------------------------
module block_interleaver
    import interleaver_pkg::*;
#(
    parameter int   ROWS    = DEF_ROWS,
    parameter int   COLS    = DEF_COLS,
    parameter logic PAD_BIT = DEF_PAD_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data,
    input  logic in_flush,
    output logic out_valid,
    input  logic out_ready,
    output logic out_data,
    output logic out_first,
    output logic out_last
);

    localparam int DEPTH = depth_of(ROWS, COLS);
    localparam int CNT_W = cnt_w_of(DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    // ---------------------------------------------------------------- state
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic             rd_bank;
    logic [CNT_W-1:0] rd_cnt;
    logic             flush_pend;   // flush seen while the write bank was busy

    // ---------------------------------------------------------------- write side
    logic accept;
    logic flush_req;
    logic wr_last;
    logic wr_close;

    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid & in_ready;
    assign flush_req = in_flush | flush_pend;
    assign wr_last   = (wr_cnt == CNT_LAST);

    // A block closes when its last position is written, or on a flush that
    // finds at least one bit in it (a bit accepted this same cycle counts).
    // A flush into an empty block is dropped.
    always_comb begin
        wr_close = 1'b0;
        if (in_ready) begin
            if (accept) begin
                wr_close = wr_last | flush_req;
            end else begin
                wr_close = flush_req & (wr_cnt != '0);
            end
        end
    end

    // ---------------------------------------------------------------- read side
    logic             rd_adv;
    logic             rd_last;
    logic             rd_done;
    logic [CNT_W-1:0] rd_addr;
    logic [1:0]       bank_rdata;

    assign out_valid = full[rd_bank];
    assign rd_adv    = out_valid & out_ready;
    assign rd_last   = (rd_cnt == CNT_LAST);
    assign rd_done   = rd_adv & rd_last;

    // Column-major read address. Outputs depend only on registered state, so
    // they stay stable while out_valid is held against !out_ready.
    assign rd_addr   = CNT_W'(perm(int'(rd_cnt), ROWS, COLS));

    assign out_data  = bank_rdata[rd_bank];
    assign out_first = out_valid & (rd_cnt == '0);
    assign out_last  = out_valid & rd_last;

    // ---------------------------------------------------------------- full flags
    // Write sets a flag only on a non-full bank and read clears only a full
    // one, so set and clear never target the same bit in one cycle.
    always_comb begin
        // NOTE: every combinational output gets its default first, so no path
        // leaves it unassigned and no latch is inferred.
        full_nxt = full;
        if (wr_close) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // ---------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= '0;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            flush_pend <= 1'b0;
        end else begin
            full <= full_nxt;

            if (wr_close) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else if (accept) begin
                wr_cnt  <= wr_cnt + 1'b1;
            end

            if (rd_done) begin
                rd_cnt  <= '0;
                rd_bank <= ~rd_bank;
            end else if (rd_adv) begin
                rd_cnt  <= rd_cnt + 1'b1;
            end

            // A pending flush is resolved the first cycle the write bank is
            // free: it either closes the block with that cycle's accept or is
            // dropped because the block is empty.
            if (in_ready) begin
                flush_pend <= 1'b0;
            end else if (in_flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- banks
    for (genvar b = 0; b < 2; b++) begin : g_bank
        ilv_bank #(
            .DEPTH   (DEPTH),
            .ADDR_W  (CNT_W),
            .PAD_BIT (PAD_BIT)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (accept & (wr_bank == 1'(b))),
            .waddr (wr_cnt),
            .wdata (in_data),
            .clr   (rd_done & (rd_bank == 1'(b))),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

endmodule

// File: tb/tb_block_interleaver.sv
// -----------------------------------------------------------------------------
// tb_block_interleaver
//   Self-checking bench for block_interleaver (4x4, PAD_BIT = 0).
//   A reference model collects accepted bits into blocks, and on each close
//   lays the block out as a ROWS x COLS matrix (row-major, padded) and queues
//   it column by column with first/last markers. Every cycle the model checks
//   in_ready (fewer than two blocks buffered) and out_valid (anything queued),
//   and each consumed output bit against the queue head.
// -----------------------------------------------------------------------------
module tb_block_interleaver;
    import interleaver_pkg::*;

    localparam int   ROWS  = 4;
    localparam int   COLS  = 4;
    localparam int   DEPTH = ROWS * COLS;
    localparam logic PAD   = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_data = 1'b0;
    logic in_flush = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic out_data;
    logic out_first;
    logic out_last;

    block_interleaver #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .PAD_BIT (PAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        logic data;
        logic first;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    logic cur[$];
    bit   pend_m = 1'b0;
    bit   cap_en = 1'b0;
    logic cap[$];
    int   cap_cyc[$];
    logic sent[$];

    always @(negedge clk) begin : model
        exp_t e;
        bit   rdy_m;
        bit   close_m;
        int   idx;
        if (rst) begin
            exp_q.delete();
            cur.delete();
            pend_m = 1'b0;
        end else begin
            // Blocks still buffered in the DUT, counting a partly read one.
            rdy_m = ((exp_q.size() + DEPTH - 1) / DEPTH) < 2;
            check("in_ready", in_ready, rdy_m);
            check("out_valid", out_valid, exp_q.size() != 0);

            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_first", out_first, e.first);
                check("out_last", out_last, e.last);
                if (cap_en) begin
                    cap.push_back(out_data);
                    cap_cyc.push_back(cyc);
                end
            end

            close_m = 1'b0;
            if (rdy_m) begin
                if (in_valid) cur.push_back(in_data);
                if (cur.size() == DEPTH) close_m = 1'b1;
                if ((in_flush || pend_m) && cur.size() != 0) close_m = 1'b1;
                pend_m = 1'b0;
            end else if (in_flush) begin
                pend_m = 1'b1;
            end

            if (close_m) begin
                for (int c = 0; c < COLS; c++) begin
                    for (int r = 0; r < ROWS; r++) begin
                        idx     = r * COLS + c;
                        e.data  = (idx < cur.size()) ? cur[idx] : PAD;
                        e.first = (r == 0) && (c == 0);
                        e.last  = (r == ROWS - 1) && (c == COLS - 1);
                        exp_q.push_back(e);
                    end
                end
                cur.delete();
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic send_bit(input logic b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        in_flush = 1'b1;
        @(posedge clk);
        #1;
        in_flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Receive-side deinterleave of the captured stream must restore 'sent'.
    task automatic check_deint(input string tag);
        check({tag, "_count"}, cap.size(), sent.size());
        if (cap.size() == sent.size()) begin
            for (int b = 0; b < sent.size() / DEPTH; b++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    check(tag, cap[b * DEPTH + k],
                          sent[b * DEPTH + (k % ROWS) * COLS + (k / ROWS)]);
                end
            end
        end
    endtask

    task automatic start_capture();
        cap.delete();
        cap_cyc.delete();
        sent.delete();
        cap_en = 1'b1;
    endtask

    logic exp5 [DEPTH] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : stim
        int   c0;
        int   n;
        int   ones;
        logic b;

        // 1. reset and idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, PAD);
        check("rst_out_first", out_first, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        repeat (20) @(posedge clk);
        #1;

        // 2. single one at input index 1 -> output index 4
        start_capture();
        for (int i = 0; i < DEPTH; i++) begin
            b = (i == 1);
            sent.push_back(b);
            send_bit(b);
        end
        @(negedge clk);
        check("t2_latency", out_valid, 1'b1);
        check("t2_first", out_first, 1'b1);
        wait_drain();
        ones = 0;
        foreach (cap[i]) ones += int'(cap[i]);
        check("t2_ones", ones, 1);
        check("t2_pos4", cap[4], 1'b1);
        check_deint("t2_deint");

        // 3. 64 random bits back to back
        start_capture();
        c0 = cyc;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            b = 1'($urandom_range(0, 1));
            sent.push_back(b);
            send_bit(b);
        end
        check("t3_in_rate", cyc - c0, 4 * DEPTH);
        wait_drain();
        check("t3_out_rate", cap_cyc[cap_cyc.size() - 1] - cap_cyc[0], 4 * DEPTH - 1);
        check_deint("t3_deint");

        // 4. back-pressure: both banks fill, then release one
        start_capture();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            b = 1'($urandom_range(0, 1));
            sent.push_back(b);
            send_bit(b);
        end
        @(negedge clk);
        check("t4_full_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_last) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_last_seen", out_last, 1'b1);
        check("t4_ready_before_release", in_ready, 1'b0);
        @(negedge clk);
        check("t4_ready_after_release", in_ready, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            b = 1'($urandom_range(0, 1));
            sent.push_back(b);
            send_bit(b);
        end
        pulse_flush();
        for (int i = 0; i < DEPTH / 2; i++) sent.push_back(PAD);
        wait_drain();
        check_deint("t4_deint");

        // 5. five ones then flush -> padded block
        start_capture();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        pulse_flush();
        wait_drain();
        check("t5_count", cap.size(), DEPTH);
        if (cap.size() == DEPTH) begin
            for (int k = 0; k < DEPTH; k++) check("t5_pattern", cap[k], exp5[k]);
        end

        // 6. reset in the middle of a block
        start_capture();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_output", cap.size(), 0);
        for (int i = 0; i < DEPTH; i++) begin
            b = 1'($urandom_range(0, 1));
            sent.push_back(b);
            send_bit(b);
        end
        wait_drain();
        check_deint("t6_deint");
        cap_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
